// File: rtl/demux_dispatch_ctrl.sv
// Dispatch sequencer in front of the 16-lane demux: addressed or round-robin lane pick, per-lane valid with timeout.
// Optional macro DISPATCH_SENT_COUNT_EN builds the delivered-word counter; otherwise sent_count is tied to 0.
//
// state | meaning
// IDLE  | in_ready high, waiting for an upstream word
// ARB   | one cycle: choose the target lane and register the selector
// SEND  | lane_valid asserted to the selected lane until accept or timeout
module demux_dispatch_ctrl #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [3:0]       in_dest,
  input  logic             in_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3:0]       selector,
  output logic [WIDTH-1:0] data_out,
  output logic [15:0]      lane_valid,
  input  logic [15:0]      lane_ready,
  output logic             busy,
  output logic [7:0]       drop_count,
  output logic [15:0]      sent_count
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       selector_q, selector_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [3:0]       dest_q, dest_d;
  logic             mode_q, mode_d;
  logic [3:0]       rr_ptr_q, rr_ptr_d;
  logic [7:0]       wait_q, wait_d;
  logic [7:0]       drop_q, drop_d;
  logic [3:0]       rr_target;
  logic             rr_hit;
  logic             deliver;

  // Round-robin search starts one past the last lane served; falls back to rr_ptr+1 when nobody is ready.
  always_comb begin
    rr_hit    = 1'b0;
    rr_target = rr_ptr_q + 4'd1;
    for (int i = 1; i <= 16; i++) begin
      if (!rr_hit && lane_ready[rr_ptr_q + 4'(i)]) begin
        rr_hit    = 1'b1;
        rr_target = rr_ptr_q + 4'(i);
      end
    end
  end

  assign deliver = (state_q == SEND) && lane_ready[selector_q];

  always_comb begin
    state_d    = state_q;
    selector_d = selector_q;
    data_d     = data_q;
    dest_d     = dest_q;
    mode_d     = mode_q;
    rr_ptr_d   = rr_ptr_q;
    wait_d     = wait_q;
    drop_d     = drop_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          dest_d  = in_dest;
          mode_d  = in_mode;
          state_d = ARB;
        end
      end
      ARB: begin
        selector_d = mode_q ? rr_target : dest_q;
        wait_d     = 8'd0;
        state_d    = SEND;
      end
      SEND: begin
        if (deliver) begin
          if (mode_q) rr_ptr_d = selector_q;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
          if (wait_d == TMO) begin
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      selector_q <= 4'd0;
      data_q     <= '0;
      dest_q     <= 4'd0;
      mode_q     <= 1'b0;
      rr_ptr_q   <= 4'd15;
      wait_q     <= 8'd0;
      drop_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      selector_q <= selector_d;
      data_q     <= data_d;
      dest_q     <= dest_d;
      mode_q     <= mode_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_q     <= wait_d;
      drop_q     <= drop_d;
    end
  end

`ifdef DISPATCH_SENT_COUNT_EN
  logic [15:0] sent_q, sent_d;

  always_comb begin
    sent_d = sent_q;
    if (deliver) sent_d = sent_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sent_q <= 16'd0;
    else        sent_q <= sent_d;
  end

  assign sent_count = sent_q;
`else
  assign sent_count = 16'd0;
`endif

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign selector   = selector_q;
  assign data_out   = data_q;
  assign drop_count = drop_q;
  assign lane_valid = (state_q == SEND) ? (16'd1 << selector_q) : 16'd0;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed bench for demux_dispatch_ctrl (TIMEOUT=4): vector table of words plus late-accept, reset and saturation sequences.
module tb_demux_dispatch_ctrl;
  localparam int W   = 16;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  in_data;
  logic [3:0]    in_dest;
  logic          in_mode;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    selector;
  logic [W-1:0]  data_out;
  logic [15:0]   lane_valid;
  logic [15:0]   lane_ready;
  logic          busy;
  logic [7:0]    drop_count;
  logic [15:0]   sent_count;

  demux_dispatch_ctrl #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_dest(in_dest), .in_mode(in_mode),
    .in_valid(in_valid), .in_ready(in_ready), .selector(selector), .data_out(data_out),
    .lane_valid(lane_valid), .lane_ready(lane_ready), .busy(busy),
    .drop_count(drop_count), .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_drop = 0;
  int exp_sent = 0;

  typedef struct {
    logic        mode;
    logic [3:0]  dest;
    logic [15:0] data;
    logic [15:0] ready;
    logic [3:0]  exp_sel;
    logic        exp_deliver;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sent_exp();
`ifdef DISPATCH_SENT_COUNT_EN
    return 16'(exp_sent);
`else
    return 16'd0;
`endif
  endfunction

  task automatic run_word(input vec_t v);
    int n;
    @(negedge clk);
    lane_ready = v.ready;
    in_data    = v.data;
    in_dest    = v.dest;
    in_mode    = v.mode;
    in_valid   = 1'b1;
    chk("in_ready_idle", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~v.data;
    in_dest  = ~v.dest;
    chk("arb_in_ready", in_ready, 1'b0);
    chk("arb_busy", busy, 1'b1);
    chk("arb_data_out", data_out, v.data);
    @(posedge clk);
    @(negedge clk);
    chk("send_selector", selector, v.exp_sel);
    chk("send_lane_valid", lane_valid, 16'd1 << v.exp_sel);
    chk("send_data_out", data_out, v.data);
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("send_cycles", n, v.exp_deliver ? 1 : TMO);
    if (v.exp_deliver) exp_sent++;
    else if (exp_drop < 255) exp_drop++;
    chk("done_in_ready", in_ready, 1'b1);
    chk("done_lane_valid", lane_valid, 16'd0);
    chk("drop_count", drop_count, exp_drop);
    chk("sent_count", sent_count, sent_exp());
  endtask

  initial begin
    vec_t v;
    vecs[0]  = '{1'b0, 4'd9,  16'hA5A5, 16'hFFFF, 4'd9,  1'b1};
    vecs[1]  = '{1'b1, 4'd4,  16'h1111, 16'hFFFF, 4'd0,  1'b1};
    vecs[2]  = '{1'b1, 4'd4,  16'h2222, 16'hFFFF, 4'd1,  1'b1};
    vecs[3]  = '{1'b1, 4'd4,  16'h3333, 16'hFFFF, 4'd2,  1'b1};
    vecs[4]  = '{1'b1, 4'd0,  16'h4444, 16'h0100, 4'd8,  1'b1};
    vecs[5]  = '{1'b1, 4'd0,  16'h5555, 16'hFFFF, 4'd9,  1'b1};
    vecs[6]  = '{1'b0, 4'd3,  16'h6666, 16'h0000, 4'd3,  1'b0};
    vecs[7]  = '{1'b1, 4'd0,  16'h7777, 16'h0000, 4'd10, 1'b0};
    vecs[8]  = '{1'b1, 4'd0,  16'h8888, 16'hFFFF, 4'd10, 1'b1};
    vecs[9]  = '{1'b0, 4'd15, 16'h9999, 16'h8000, 4'd15, 1'b1};
    vecs[10] = '{1'b1, 4'd0,  16'hAAAA, 16'h0003, 4'd0,  1'b1};
    vecs[11] = '{1'b0, 4'd5,  16'hBBBB, 16'hFFDF, 4'd5,  1'b0};

    rst_n = 1'b0; in_data = '0; in_dest = '0; in_mode = 1'b0; in_valid = 1'b0; lane_ready = '0;
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_selector", selector, 4'd0);
    chk("rst_data_out", data_out, 16'd0);
    chk("rst_lane_valid", lane_valid, 16'd0);
    chk("rst_drop", drop_count, 8'd0);
    chk("rst_sent", sent_count, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_word(vecs[i]);

    // Late accept: lane 3 becomes ready on the last permitted SEND cycle.
    @(negedge clk);
    lane_ready = '0; in_data = 16'hC0DE; in_dest = 4'd3; in_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("late_lane_valid1", lane_valid, 16'h0008);
    for (int c = 2; c <= TMO; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("late_lane_valid", lane_valid, 16'h0008);
    end
    lane_ready = 16'h0008;
    @(posedge clk);
    @(negedge clk);
    exp_sent++;
    chk("late_busy", busy, 1'b0);
    chk("late_drop", drop_count, exp_drop);
    chk("late_sent", sent_count, sent_exp());
    lane_ready = '0;

    // Async reset while a word is in SEND.
    @(negedge clk);
    in_data = 16'hDEAD; in_dest = 4'd7; in_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_lane_valid", lane_valid, 16'h0080);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_lane_valid", lane_valid, 16'd0);
    chk("mid_rst_selector", selector, 4'd0);
    chk("mid_rst_busy", busy, 1'b0);
    exp_drop = 0; exp_sent = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_drop", drop_count, 8'd0);
    chk("post_rst_sent", sent_count, 16'd0);
    v = '{1'b1, 4'd0, 16'h1234, 16'hFFFF, 4'd0, 1'b1};
    run_word(v);

    // Drop saturation.
    v = '{1'b0, 4'd3, 16'h5A5A, 16'h0000, 4'd3, 1'b0};
    for (int k = 0; k < 300; k++) run_word(v);
    chk("drop_saturated", drop_count, 8'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
